tx_ffe_sweep_ctrl: RTL and testbench
====================================

Name: tx_ffe_sweep_ctrl

Overview:
- Sequencer that configures the TX FFE coefficient-set select (tx_setting).
- Steps tx_setting from setting_min to setting_max. At each step it clears the FFE input history, waits a settle interval, then gates an error-measurement window.
- After each step it reports the error count over a valid/ready handshake, tracks the lowest-error setting, and applies the best setting when the sweep completes.
- Sits between the link test controller / error checker and tx_ffe.

Parameters:
- TX_SETTING_WIDTH, 4, width of tx_setting and the sweep bounds.
- DWELL_WIDTH, 16, width of the measurement-window length.
- ERR_WIDTH, 16, width of the error counters; counters saturate.
- SETTLE_CYCLES, 64, cycles between FFE history clear and measurement start; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level; rising to high in IDLE launches a sweep.
- abort  in  1  pulse; cancels any sweep.
- setting_min  in  TX_SETTING_WIDTH  first setting; latched at start.
- setting_max  in  TX_SETTING_WIDTH  last setting; latched at start.
- dwell_len  in  DWELL_WIDTH  measurement cycles per setting; latched at start; 0 is treated as 1.
- err_in  in  1  error strobe from the checker; counted only while meas_en=1.
- tx_setting  out  TX_SETTING_WIDTH  drives tx_ffe tx_setting.
- ffe_rst  out  1  active-high synchronous history clear to tx_ffe.
- meas_en  out  1  measurement window active.
- result_valid  out  1  per-setting result available.
- result_ready  in  1  consumer accepts the result.
- result_setting  out  TX_SETTING_WIDTH  setting being reported.
- result_errs  out  ERR_WIDTH  errors counted for that setting.
- best_setting  out  TX_SETTING_WIDTH  lowest-error setting found so far.
- busy  out  1  state is neither IDLE nor DONE.
- done  out  1  sweep complete; best setting applied.
- cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - tx_setting=0, best_setting=0, result_setting=0, result_errs=0.
  - ffe_rst=1; all other outputs 0.
  - ffe_rst deasserts on the first clock after reset release.
- Latency summary:
  - start → ffe_rst asserted: 2 cycles.
  - meas_en first high: 1+SETTLE_CYCLES cycles after the LOAD cycle.
- IDLE: on start=1 with setting_min≤setting_max:
  - Latch bounds and dwell_len; cur=setting_min; best_err=all-ones; go to LOAD.
  - If setting_min>setting_max: pulse cfg_err for 1 cycle and stay in IDLE. start must fall before it is sampled again.
- LOAD (1 cycle):
  - tx_setting<=cur; ffe_rst=1 for exactly this cycle; err counter cleared.
  - Next state: SETTLE.
- SETTLE: down-counter runs SETTLE_CYCLES cycles with meas_en=0, then go to MEASURE.
- MEASURE:
  - meas_en=1 for exactly max(dwell_len,1) cycles.
  - err counter +1 on each cycle with err_in=1; saturates at 2^ERR_WIDTH−1.
  - err_in outside MEASURE is ignored.
  - Next state: REPORT.
- REPORT:
  - result_valid=1; result_setting=cur; result_errs=count. All three are held stable until result_ready=1.
  - On handshake: if count<best_err, then best_err=count and best_setting=cur. Ties keep the earlier (lower) setting.
  - Then: if cur==setting_max, go to DONE; otherwise cur=cur+1 and go to LOAD.
  - The comparison happens before the increment, so a sweep ending at an all-ones setting never wraps.
  - result_valid drops the cycle after the handshake. result_ready outside REPORT is ignored.
- DONE:
  - tx_setting<=best_setting; ffe_rst=1 for the first DONE cycle only; done=1.
  - Remain in DONE while start=1; go to IDLE when start=0. tx_setting is retained in IDLE.
- abort=1 in any state except IDLE: next state is IDLE.
  - meas_en, result_valid and busy clear.
  - tx_setting and best_setting hold their current values; no ffe_rst.
  - abort and result_ready asserted together: abort wins and the result is not consumed.
- A single-setting sweep (min==max) performs one LOAD/SETTLE/MEASURE/REPORT pass; best_setting=min.

Test Plan:
- Reset release, no start → tx_setting=0, ffe_rst=1 only until the first clock after release, all other outputs 0.
- Sweep 2..5, dwell_len=100, SETTLE_CYCLES=64, result_ready tied 1, err_in injected at 30/5/5/12 per step:
  - 4 results reported with those counts and settings.
  - best_setting=3 (tie resolved to the lower setting); done=1; tx_setting=3.
  - meas_en high exactly 100 cycles per step.
- dwell_len=0, single setting 7 → meas_en high 1 cycle; one result with setting 7; done.
- Sweep 14..15 (4-bit), result_ready held 0 for 20 cycles in REPORT:
  - result fields stable throughout; no wrap past 15; done after 2 results.
- abort asserted mid-MEASURE of setting 4 (sweep 3..6):
  - IDLE next cycle; meas_en=0, busy=0; tx_setting=4; no further results.
- setting_min=9, setting_max=2 with start=1 → cfg_err 1-cycle pulse; busy stays 0; tx_setting unchanged.
- err_in held high for 70000 cycles in one window (dwell_len=65535) → result_errs=65535 (saturated).

Source files
------------

// File: rtl/tx_ffe_sweep_ctrl.sv
// TX FFE coefficient sweep sequencer: steps tx_setting across a range, measures errors per step,
// reports each result over valid/ready and applies the lowest-error setting at the end.
module tx_ffe_sweep_ctrl #(
  parameter int unsigned TX_SETTING_WIDTH = 4,
  parameter int unsigned DWELL_WIDTH      = 16,
  parameter int unsigned ERR_WIDTH        = 16,
  parameter int unsigned SETTLE_CYCLES    = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic [TX_SETTING_WIDTH-1:0] i_setting_min,
  input  logic [TX_SETTING_WIDTH-1:0] i_setting_max,
  input  logic [DWELL_WIDTH-1:0]      i_dwell_len,
  input  logic                        i_err_in,
  output logic [TX_SETTING_WIDTH-1:0] o_tx_setting,
  output logic                        o_ffe_rst,
  output logic                        o_meas_en,
  output logic                        o_result_valid,
  input  logic                        i_result_ready,
  output logic [TX_SETTING_WIDTH-1:0] o_result_setting,
  output logic [ERR_WIDTH-1:0]        o_result_errs,
  output logic [TX_SETTING_WIDTH-1:0] o_best_setting,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_cfg_err
);

  localparam int unsigned SW       = TX_SETTING_WIDTH;
  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TMR_W    = (DWELL_WIDTH > SETTLE_W) ? DWELL_WIDTH : SETTLE_W;

  localparam logic [TMR_W-1:0]     SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX     = {ERR_WIDTH{1'b1}};

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_REPORT  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]             r_state,    w_state_nxt;
  logic                   r_start_q,  r_start_qq;
  logic [SW-1:0]          r_max,      w_max_nxt;
  logic [DWELL_WIDTH-1:0] r_dwell,    w_dwell_nxt;
  logic [SW-1:0]          r_cur,      w_cur_nxt;
  logic [ERR_WIDTH-1:0]   r_best_err, w_best_err_nxt;
  logic [SW-1:0]          r_best_set, w_best_set_nxt;
  logic [ERR_WIDTH-1:0]   r_cnt,      w_cnt_nxt;
  logic [TMR_W-1:0]       r_tmr,      w_tmr_nxt;
  logic [SW-1:0]          r_tx,       w_tx_nxt;
  logic                   r_ffe_rst,  w_ffe_rst_nxt;
  logic                   r_meas_en,  w_meas_en_nxt;
  logic                   r_valid,    w_valid_nxt;
  logic                   r_busy,     w_busy_nxt;
  logic                   r_done,     w_done_nxt;
  logic                   r_cfg_err,  w_cfg_err_nxt;
  logic                   w_start_rise;

  // start is a level; only a fresh rise may launch a sweep
  assign w_start_rise = r_start_q & ~r_start_qq;

  always_comb begin
    w_state_nxt    = r_state;
    w_max_nxt      = r_max;
    w_dwell_nxt    = r_dwell;
    w_cur_nxt      = r_cur;
    w_best_err_nxt = r_best_err;
    w_best_set_nxt = r_best_set;
    w_cnt_nxt      = r_cnt;
    w_tmr_nxt      = r_tmr;
    w_cfg_err_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start_rise) begin
          if (i_setting_min > i_setting_max) begin
            w_cfg_err_nxt = 1'b1;
          end else begin
            w_max_nxt      = i_setting_max;
            w_dwell_nxt    = (i_dwell_len == '0) ? DWELL_WIDTH'(1) : i_dwell_len;
            w_cur_nxt      = i_setting_min;
            w_best_err_nxt = ERR_MAX;
            w_state_nxt    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        w_cnt_nxt   = '0;
        w_tmr_nxt   = SETTLE_LOAD;
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_tmr == '0) begin
          w_tmr_nxt   = TMR_W'(r_dwell - DWELL_WIDTH'(1));
          w_state_nxt = S_MEASURE;
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end
      S_MEASURE: begin
        if (i_err_in && (r_cnt != ERR_MAX)) w_cnt_nxt = r_cnt + ERR_WIDTH'(1);
        if (r_tmr == '0) w_state_nxt = S_REPORT;
        else             w_tmr_nxt   = r_tmr - TMR_W'(1);
      end
      S_REPORT: begin
        // strict less-than keeps the earlier setting on ties; end check precedes increment
        if (i_result_ready) begin
          if (r_cnt < r_best_err) begin
            w_best_err_nxt = r_cnt;
            w_best_set_nxt = r_cur;
          end
          if (r_cur == r_max) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cur_nxt   = r_cur + SW'(1);
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_DONE: begin
        if (!i_start) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // abort overrides everything, including a coincident result handshake
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_nxt    = S_IDLE;
      w_cur_nxt      = r_cur;
      w_best_err_nxt = r_best_err;
      w_best_set_nxt = r_best_set;
    end

    w_busy_nxt    = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    w_meas_en_nxt = (w_state_nxt == S_MEASURE);
    w_valid_nxt   = (w_state_nxt == S_REPORT);
    w_done_nxt    = (w_state_nxt == S_DONE);
    w_ffe_rst_nxt = (w_state_nxt == S_LOAD) ||
                    ((w_state_nxt == S_DONE) && (r_state != S_DONE));
    w_tx_nxt      = r_tx;
    if (w_state_nxt == S_LOAD)                                 w_tx_nxt = w_cur_nxt;
    else if ((w_state_nxt == S_DONE) && (r_state != S_DONE))   w_tx_nxt = w_best_set_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_start_q  <= 1'b0;
      r_start_qq <= 1'b0;
      r_max      <= '0;
      r_dwell    <= '0;
      r_cur      <= '0;
      r_best_err <= ERR_MAX;
      r_best_set <= '0;
      r_cnt      <= '0;
      r_tmr      <= '0;
      r_tx       <= '0;
      r_ffe_rst  <= 1'b1;
      r_meas_en  <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_start_q  <= i_start;
      r_start_qq <= r_start_q;
      r_max      <= w_max_nxt;
      r_dwell    <= w_dwell_nxt;
      r_cur      <= w_cur_nxt;
      r_best_err <= w_best_err_nxt;
      r_best_set <= w_best_set_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tmr      <= w_tmr_nxt;
      r_tx       <= w_tx_nxt;
      r_ffe_rst  <= w_ffe_rst_nxt;
      r_meas_en  <= w_meas_en_nxt;
      r_valid    <= w_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_cfg_err  <= w_cfg_err_nxt;
    end
  end

  assign o_tx_setting     = r_tx;
  assign o_ffe_rst        = r_ffe_rst;
  assign o_meas_en        = r_meas_en;
  assign o_result_valid   = r_valid;
  assign o_result_setting = r_cur;
  assign o_result_errs    = r_cnt;
  assign o_best_setting   = r_best_set;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_cfg_err        = r_cfg_err;

endmodule

// File: tb/tb_tx_ffe_sweep_ctrl.sv
// Directed bench for tx_ffe_sweep_ctrl; a narrow-counter instance shares the stimulus
// to exercise error-count saturation.
module tb_tx_ffe_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, ready, err_in;
  logic [3:0]  set_min, set_max;
  logic [15:0] dwell;

  logic [3:0]  tx_setting, res_setting, best_setting;
  logic [15:0] res_errs;
  logic        ffe_rst, meas_en, res_valid, busy, done, cfg_err;

  logic [3:0]  s_tx_setting, s_res_setting, s_best_setting;
  logic [3:0]  s_res_errs;
  logic        s_ffe_rst, s_meas_en, s_res_valid, s_busy, s_done, s_cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  // monitor state
  int cyc = 0, t_load = 0, last_gap = 0, meas_run = 0, step_idx = 0, inj_left = 0;
  bit gap_seen = 1'b0;
  bit force_err = 1'b0;
  int inj_tbl[64];
  int meas_q[$];
  int res_set_q[$];
  int res_err_q[$];

  int exp_set2[4] = '{2, 3, 4, 5};
  int exp_err2[4] = '{30, 5, 5, 12};

  always #5 clk = ~clk;

  tx_ffe_sweep_ctrl u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_setting_min(set_min), .i_setting_max(set_max), .i_dwell_len(dwell),
    .i_err_in(err_in), .o_tx_setting(tx_setting), .o_ffe_rst(ffe_rst),
    .o_meas_en(meas_en), .o_result_valid(res_valid), .i_result_ready(ready),
    .o_result_setting(res_setting), .o_result_errs(res_errs),
    .o_best_setting(best_setting), .o_busy(busy), .o_done(done), .o_cfg_err(cfg_err)
  );

  tx_ffe_sweep_ctrl #(.ERR_WIDTH(4)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_setting_min(set_min), .i_setting_max(set_max), .i_dwell_len(dwell),
    .i_err_in(err_in), .o_tx_setting(s_tx_setting), .o_ffe_rst(s_ffe_rst),
    .o_meas_en(s_meas_en), .o_result_valid(s_res_valid), .i_result_ready(ready),
    .o_result_setting(s_res_setting), .o_result_errs(s_res_errs),
    .o_best_setting(s_best_setting), .o_busy(s_busy), .o_done(s_done), .o_cfg_err(s_cfg_err)
  );

  // Negedge monitor: window lengths, LOAD-to-window gap, accepted results, error injection
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ffe_rst && busy) begin
      t_load   = cyc;
      gap_seen = 1'b0;
      inj_left = (step_idx < 64) ? inj_tbl[step_idx] : 0;
      step_idx = step_idx + 1;
    end
    if (meas_en) begin
      meas_run = meas_run + 1;
      if (!gap_seen) begin
        last_gap = cyc - t_load;
        gap_seen = 1'b1;
      end
    end else if (meas_run != 0) begin
      meas_q.push_back(meas_run);
      meas_run = 0;
    end
    if (res_valid && ready) begin
      res_set_q.push_back(int'(res_setting));
      res_err_q.push_back(int'(res_errs));
    end
    err_in = force_err || (meas_en && (inj_left > 0));
    if (meas_en && (inj_left > 0)) inj_left = inj_left - 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  base_res, base_meas, base_step;
  bit  ok, stable;
  logic [3:0]  hold_set;
  logic [15:0] hold_err;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
    set_min = '0; set_max = '0; dwell = '0;

    // reset state
    tick(); tick();
    check_eq("rst_tx", 32'(tx_setting), 0);
    check_eq("rst_ffe_rst", 32'(ffe_rst), 1);
    check_eq("rst_outs", 32'({meas_en, res_valid, busy, done, cfg_err}), 0);
    check_eq("rst_res", 32'({best_setting, res_setting, res_errs}), 0);
    rst_n = 1'b1;
    #2;
    check_eq("rel_ffe_rst_held", 32'(ffe_rst), 1);
    tick();
    check_eq("rel_ffe_rst_clr", 32'(ffe_rst), 0);
    check_eq("rel_idle", 32'({busy, done, meas_en, res_valid, tx_setting}), 0);

    // sweep 2..5, ready tied high
    base_res = res_set_q.size(); base_meas = meas_q.size(); base_step = step_idx;
    for (int k = 0; k < 4; k++) inj_tbl[base_step + k] = exp_err2[k];
    set_min = 4'd2; set_max = 4'd5; dwell = 16'd100; ready = 1'b1; start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin tick(); if (done) begin ok = 1'b1; break; end end
    check_eq("sw_done_wait", 32'(ok), 1);
    check_eq("sw_nres", 32'(res_set_q.size() - base_res), 4);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("sw_set%0d", k), 32'(res_set_q[base_res + k]), 32'(exp_set2[k]));
      check_eq($sformatf("sw_err%0d", k), 32'(res_err_q[base_res + k]), 32'(exp_err2[k]));
      check_eq($sformatf("sw_meas%0d", k), 32'(meas_q[base_meas + k]), 100);
    end
    check_eq("sw_best", 32'(best_setting), 3);
    check_eq("sw_tx", 32'(tx_setting), 3);
    check_eq("sw_busy", 32'(busy), 0);
    start = 1'b0; tick(); tick();
    check_eq("sw_back_idle", 32'(done), 0);

    // single setting 7, dwell 0, plus launch latency
    base_res = res_set_q.size(); base_meas = meas_q.size();
    set_min = 4'd7; set_max = 4'd7; dwell = 16'd0; start = 1'b1;
    tick();
    check_eq("lat_ffe_rst_c1", 32'(ffe_rst), 0);
    tick();
    check_eq("lat_ffe_rst_c2", 32'(ffe_rst), 1);
    check_eq("lat_tx", 32'(tx_setting), 7);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin tick(); if (done) begin ok = 1'b1; break; end end
    check_eq("one_done_wait", 32'(ok), 1);
    check_eq("one_meas_len", 32'(meas_q[base_meas]), 1);
    check_eq("one_gap", 32'(last_gap), 65);
    check_eq("one_nres", 32'(res_set_q.size() - base_res), 1);
    check_eq("one_set", 32'(res_set_q[base_res]), 7);
    check_eq("one_best", 32'(best_setting), 7);
    start = 1'b0; tick(); tick();

    // sweep 14..15 with backpressure in REPORT
    base_res = res_set_q.size();
    set_min = 4'd14; set_max = 4'd15; dwell = 16'd10; ready = 1'b0; start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin tick(); if (res_valid) begin ok = 1'b1; break; end end
    check_eq("bp_valid_wait", 32'(ok), 1);
    hold_set = res_setting; hold_err = res_errs; stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!res_valid || res_setting !== hold_set || res_errs !== hold_err) stable = 1'b0;
    end
    check_eq("bp_stable", 32'(stable), 1);
    check_eq("bp_set", 32'(hold_set), 14);
    ready = 1'b1;
    tick();
    check_eq("bp_valid_drop", 32'(res_valid), 0);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin tick(); if (done) begin ok = 1'b1; break; end end
    check_eq("bp_done_wait", 32'(ok), 1);
    repeat (5) tick();
    check_eq("bp_nres", 32'(res_set_q.size() - base_res), 2);
    check_eq("bp_set2", 32'(res_set_q[base_res + 1]), 15);
    check_eq("bp_still_done", 32'({done, busy}), 32'(2'b10));
    check_eq("bp_tx", 32'(tx_setting), 14);
    start = 1'b0; tick(); tick();

    // abort during MEASURE of setting 4 in sweep 3..6
    base_res = res_set_q.size();
    set_min = 4'd3; set_max = 4'd6; dwell = 16'd100; start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (meas_en && tx_setting == 4'd4) begin ok = 1'b1; break; end
    end
    check_eq("ab_reach_meas", 32'(ok), 1);
    repeat (10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("ab_meas_en", 32'(meas_en), 0);
    check_eq("ab_busy", 32'(busy), 0);
    check_eq("ab_tx", 32'(tx_setting), 4);
    check_eq("ab_best", 32'(best_setting), 3);
    repeat (300) tick();
    check_eq("ab_nres", 32'(res_set_q.size() - base_res), 1);
    check_eq("ab_idle", 32'({busy, done, res_valid}), 0);
    start = 1'b0; tick(); tick();

    // inverted bounds rejected
    set_min = 4'd9; set_max = 4'd2; start = 1'b1;
    tick();
    check_eq("cfg_c1", 32'(cfg_err), 0);
    tick();
    check_eq("cfg_c2", 32'(cfg_err), 1);
    check_eq("cfg_busy", 32'(busy), 0);
    tick();
    check_eq("cfg_c3", 32'(cfg_err), 0);
    check_eq("cfg_tx", 32'(tx_setting), 4);
    start = 1'b0; tick(); tick();

    // error counter saturation: full 65535-cycle window with err_in stuck high
    set_min = 4'd1; set_max = 4'd1; dwell = 16'hFFFF; ready = 1'b1;
    force_err = 1'b1; start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 70000; i++) begin tick(); if (res_valid) begin ok = 1'b1; break; end end
    check_eq("sat_valid_wait", 32'(ok), 1);
    check_eq("sat_errs16", 32'(res_errs), 65535);
    check_eq("sat_errs4", 32'(s_res_errs), 15);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (done) begin ok = 1'b1; break; end end
    check_eq("sat_done", 32'(ok), 1);
    force_err = 1'b0; start = 1'b0; tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
